// File: rtl/Router_library.sv
// Shared mesh packet layout, destination-field extract helpers and terminal FSM state codes.
// Field offsets count down from the packet MSB so any packet width >= 17 bits decodes the same way.
package Router_library;

  localparam int MAX_PCKG_SZ     = 256;
  localparam int NXT_JMP_W       = 8;
  localparam int ROW_W           = 4;
  localparam int COL_W           = 4;
  localparam int NXT_JMP_MSB_OFS = 1;
  localparam int ROW_MSB_OFS     = 9;
  localparam int COL_MSB_OFS     = 13;
  localparam int MODE_OFS        = 17;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef logic [MAX_PCKG_SZ-1:0] pkt_ext_t;

  function automatic logic [ROW_W-1:0] get_dest_row(input pkt_ext_t pkt, input int sz);
    pkt_ext_t sh;
    sh = pkt >> (sz - ROW_MSB_OFS - ROW_W + 1);
    return sh[ROW_W-1:0];
  endfunction

  function automatic logic [COL_W-1:0] get_dest_col(input pkt_ext_t pkt, input int sz);
    pkt_ext_t sh;
    sh = pkt >> (sz - COL_MSB_OFS - COL_W + 1);
    return sh[COL_W-1:0];
  endfunction

endpackage

// File: rtl/term_rx_fifo.sv
// First-word fall-through receive buffer, zero-latency read of the head entry.
// Writes are refused when full and reads are ignored when empty; pointers wrap modulo depth.
module term_rx_fifo #(
  parameter int pckg_sz    = 32,
  parameter int fifo_depth = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_vld,
  input  logic [pckg_sz-1:0]            wr_dat,
  input  logic                          rd_rdy,
  output logic [pckg_sz-1:0]            rd_dat,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(fifo_depth);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               do_wr;
  logic               do_rd;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_rx.sv
// Mesh terminal receiver: pops the exit port at most once per 3 cycles, keeps packets addressed here.
// Pops only when the buffer has room, so a stalled consumer holds packets in the mesh instead of losing them.
module mesh_term_rx
  import Router_library::*;
#(
  parameter int         pckg_sz    = 32,
  parameter int         fifo_depth = 8,
  parameter logic [3:0] ROW_ID     = 4'd4,
  parameter logic [3:0] COL_ID     = 4'd5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  input  logic               clr_stats,
  output logic [15:0]        rx_count,
  output logic [15:0]        err_count,
  output logic               err_flag,
  output logic               fifo_full
);

  localparam int CNT_W = $clog2(fifo_depth) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(fifo_depth);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  pkt_ext_t         pkt_ext;
  logic             capture;
  logic             hit;
  logic             push;
  logic             misroute;

  always_comb begin
    pkt_ext = '0;
    pkt_ext[pckg_sz-1:0] = data_out;
  end

  // The exit port is only trusted on the last cycle of POP, when pop has been seen by the mesh.
  assign capture  = (state == ST_POP) && pndng;
  assign hit      = (get_dest_row(pkt_ext, pckg_sz) == ROW_ID) &&
                    (get_dest_col(pkt_ext, pckg_sz) == COL_ID);
  assign push     = capture && hit;
  assign misroute = capture && !hit;
  assign rx_valid = !fifo_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pndng && (fifo_count < DEPTH_C)) state_nxt = ST_POP;
      ST_POP:  state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      pop   <= 1'b0;
    end else begin
      state <= state_nxt;
      pop   <= (state_nxt == ST_POP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count  <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (clr_stats) begin
      rx_count  <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (push && (rx_count != 16'hFFFF))      rx_count  <= rx_count + 16'd1;
      if (misroute && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (misroute)                            err_flag  <= 1'b1;
    end
  end

  term_rx_fifo #(
    .pckg_sz    (pckg_sz),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat (data_out),
    .rd_rdy (rx_ready),
    .rd_dat (rx_data),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_mesh_term_rx.sv
// Scoreboarded bench for mesh_term_rx: a modelled mesh exit port feeds packets, a monitor checks delivered data.
module tb_mesh_term_rx;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        pndng     = 1'b0;
  logic [31:0] data_out  = '0;
  logic        pop;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready  = 1'b0;
  logic        clr_stats = 1'b0;
  logic [15:0] rx_count;
  logic [15:0] err_count;
  logic        err_flag;
  logic        fifo_full;

  int checks = 0;
  int errors = 0;

  logic [31:0] mesh_q[$];
  logic [31:0] exp_q[$];
  logic        pop_prev = 1'b0;

  localparam logic [31:0] PKT_HIT  = 32'b00000000_0100_0101_1_10101010_0101010;
  localparam logic [31:0] PKT_MISS = 32'h0735_8123;

  always #5 clk = ~clk;

  mesh_term_rx #(
    .pckg_sz    (32),
    .fifo_depth (8),
    .ROW_ID     (4'd4),
    .COL_ID     (4'd5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .data_out  (data_out),
    .pop       (pop),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .clr_stats (clr_stats),
    .rx_count  (rx_count),
    .err_count (err_count),
    .err_flag  (err_flag),
    .fifo_full (fifo_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mesh exit port model: the head leaves in the cycle after the one where pop was high.
  always @(posedge clk) pop_prev <= pop;

  always @(negedge clk) begin
    if (pop_prev && mesh_q.size() > 0) void'(mesh_q.pop_front());
    pndng    = (mesh_q.size() != 0);
    data_out = (mesh_q.size() != 0) ? mesh_q[0] : 32'h0;
  end

  // Each negedge with valid & ready marks one transfer at the following posedge.
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected no packet", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] mk_pkt(input logic [3:0] row, input logic [3:0] col,
                                         input logic [15:0] pay);
    return {8'h11, row, col, pay};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pop(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (pop) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int prev;
    int npops;
    int popcnt;

    #1;
    check("rst_pop", pop, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_flag", err_flag, 0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // single matching packet
    mesh_q.push_back(PKT_HIT);
    exp_q.push_back(PKT_HIT);
    wait_pop(4, lat);
    check("hit_pop_seen", (lat >= 1 && lat <= 2), 1);
    tick(1);
    check("hit_pop_width", pop, 0);
    tick(3);
    check("hit_rx_valid", rx_valid, 1);
    check("hit_rx_count", rx_count, 1);
    check("hit_err_count", err_count, 0);
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    check("hit_drained", rx_valid, 0);

    // misrouted packet
    mesh_q.push_back(PKT_MISS);
    wait_pop(4, lat);
    check("miss_pop_seen", (lat != -1), 1);
    tick(4);
    check("miss_err_count", err_count, 1);
    check("miss_err_flag", err_flag, 1);
    check("miss_rx_valid", rx_valid, 0);
    check("miss_rx_count", rx_count, 1);
    check("miss_mesh_empty", mesh_q.size(), 0);

    // backpressure: nine packets, buffer holds eight
    for (int i = 0; i < 9; i++) begin
      mesh_q.push_back(mk_pkt(4'd4, 4'd5, 16'hB000 + 16'(i)));
      exp_q.push_back(mk_pkt(4'd4, 4'd5, 16'hB000 + 16'(i)));
    end
    tick(40);
    check("bp_fifo_full", fifo_full, 1);
    check("bp_mesh_left", mesh_q.size(), 1);
    check("bp_pndng", pndng, 1);
    check("bp_rx_count", rx_count, 9);
    popcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (pop) popcnt++;
    end
    check("bp_pop_held", popcnt, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    wait_pop(3, lat);
    check("bp_ninth_pop", (lat != -1), 1);
    rx_ready = 1'b1;
    tick(30);
    check("bp_mesh_empty", mesh_q.size(), 0);
    check("bp_rx_count_end", rx_count, 10);
    check("bp_all_delivered", exp_q.size(), 0);
    check("bp_fifo_not_full", fifo_full, 0);

    // back-to-back with consumer ready
    for (int i = 0; i < 4; i++) begin
      mesh_q.push_back(mk_pkt(4'd4, 4'd5, 16'hC0C0 + 16'(i)));
      exp_q.push_back(mk_pkt(4'd4, 4'd5, 16'hC0C0 + 16'(i)));
    end
    prev  = -1;
    npops = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (pop) begin
        if (prev >= 0) check("b2b_gap", c - prev, 3);
        prev = c;
        npops++;
      end
    end
    check("b2b_pops", npops, 4);
    check("b2b_delivered", exp_q.size(), 0);
    check("b2b_rx_count", rx_count, 14);

    // clear colliding with a capture
    rx_ready = 1'b0;
    mesh_q.push_back(mk_pkt(4'd4, 4'd5, 16'hD00D));
    exp_q.push_back(mk_pkt(4'd4, 4'd5, 16'hD00D));
    wait_pop(4, lat);
    check("clr_pop_seen", (lat != -1), 1);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    check("clr_rx_count", rx_count, 0);
    check("clr_err_count", err_count, 0);
    check("clr_err_flag", err_flag, 0);
    check("clr_buffered", rx_valid, 1);
    rx_ready = 1'b1;
    tick(3);
    rx_ready = 1'b0;
    check("clr_delivered", exp_q.size(), 0);

    // reset asserted during a pop cycle
    mesh_q.push_back(mk_pkt(4'd4, 4'd5, 16'hAAAA));
    tick(6);
    check("rst_pre_buffered", rx_valid, 1);
    mesh_q.push_back(mk_pkt(4'd4, 4'd5, 16'hBBBB));
    wait_pop(4, lat);
    check("rst_pop_seen", (lat != -1), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstpop_pop", pop, 0);
    check("rstpop_rx_valid", rx_valid, 0);
    check("rstpop_fifo_full", fifo_full, 0);
    check("rstpop_rx_count", rx_count, 0);
    tick(2);
    exp_q.push_back(mk_pkt(4'd4, 4'd5, 16'hBBBB));
    reset    = 1'b1;
    rx_ready = 1'b1;
    tick(8);
    check("rstpop_resume_count", rx_count, 1);
    check("rstpop_resume_delivered", exp_q.size(), 0);
    check("rstpop_mesh_empty", mesh_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
